// File: rtl/matrix_frame_buffer.sv
// Double-buffered 2-plane 8x8 LED matrix frame store.
// Back buffer takes row writes and clears; swap waits for a frame boundary.
module matrix_frame_buffer #(
    parameter logic [7:0] CLEAR_VALUE = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic       wr_color,
    input  logic [2:0] wr_row,
    input  logic [7:0] wr_mask,
    input  logic [7:0] wr_data,
    input  logic       clear_req,
    input  logic       swap_req,
    input  logic       frame_start,
    output logic       swap_pending,
    output logic       swap_done,
    output logic       busy,
    input  logic       rd_color,
    input  logic [2:0] rd_row,
    output logic [7:0] rd_data
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CLEAR     = 2'd1,
        SWAP_WAIT = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic       front_sel;
    logic [3:0] clr_idx;
    logic [7:0] buf_a [16];
    logic [7:0] buf_b [16];

    logic       wr_fire;
    logic       clr_we;
    logic       swap_fire;
    logic [3:0] wr_idx;
    logic [3:0] rd_idx;
    logic [7:0] back_row;
    logic [7:0] wr_merge;

    assign wr_idx = {wr_color, wr_row};
    assign rd_idx = {rd_color, rd_row};

    assign wr_ready     = (state == IDLE) && !rst;
    assign wr_fire      = wr_valid && wr_ready;
    assign busy         = (state != IDLE);
    assign swap_pending = (state == SWAP_WAIT);

    // Masked read-modify-write of the addressed back-buffer row.
    always_comb begin
        back_row = front_sel ? buf_a[wr_idx] : buf_b[wr_idx];
        wr_merge = (back_row & ~wr_mask) | (wr_data & wr_mask);
    end

    // Next-state logic; clear wins over swap when both arrive in IDLE.
    always_comb begin
        state_nxt = state;
        clr_we    = 1'b0;
        swap_fire = 1'b0;
        case (state)
            IDLE: begin
                if (clear_req) begin
                    state_nxt = CLEAR;
                end else if (swap_req) begin
                    state_nxt = SWAP_WAIT;
                end
            end
            CLEAR: begin
                clr_we = 1'b1;
                if (clr_idx == 4'd15) begin
                    state_nxt = IDLE;
                end
            end
            SWAP_WAIT: begin
                if (frame_start) begin
                    swap_fire = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register, clear sweep index, front select and swap pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            clr_idx   <= 4'd0;
            front_sel <= 1'b0;
            swap_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            swap_done <= swap_fire;
            if (clr_we) begin
                clr_idx <= clr_idx + 4'd1;
            end
            if (swap_fire) begin
                front_sel <= ~front_sel;
            end
        end
    end

    // Buffer A storage; only written while it is the back buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                buf_a[i] <= CLEAR_VALUE;
            end
        end else if (front_sel) begin
            if (clr_we) begin
                buf_a[clr_idx] <= CLEAR_VALUE;
            end else if (wr_fire) begin
                buf_a[wr_idx] <= wr_merge;
            end
        end
    end

    // Buffer B storage; only written while it is the back buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                buf_b[i] <= CLEAR_VALUE;
            end
        end else if (!front_sel) begin
            if (clr_we) begin
                buf_b[clr_idx] <= CLEAR_VALUE;
            end else if (wr_fire) begin
                buf_b[wr_idx] <= wr_merge;
            end
        end
    end

    // Registered scan-side read of the current front buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= 8'h00;
        end else begin
            rd_data <= front_sel ? buf_b[rd_idx] : buf_a[rd_idx];
        end
    end

endmodule

// File: tb/tb_matrix_frame_buffer.sv
// Self-checking bench for matrix_frame_buffer.
// Directed scenarios plus randomized traffic against a frame-level model.
module tb_matrix_frame_buffer;

    localparam logic [7:0] CV = 8'h00;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic       wr_color = 1'b0;
    logic [2:0] wr_row = 3'd0;
    logic [7:0] wr_mask = 8'h00;
    logic [7:0] wr_data = 8'h00;
    logic       clear_req = 1'b0;
    logic       swap_req = 1'b0;
    logic       frame_start = 1'b0;
    logic       swap_pending;
    logic       swap_done;
    logic       busy;
    logic       rd_color = 1'b0;
    logic [2:0] rd_row = 3'd0;
    logic [7:0] rd_data;

    int checks = 0;
    int failures = 0;
    bit started = 0;

    matrix_frame_buffer #(.CLEAR_VALUE(CV)) dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_color(wr_color), .wr_row(wr_row),
        .wr_mask(wr_mask), .wr_data(wr_data),
        .clear_req(clear_req), .swap_req(swap_req),
        .frame_start(frame_start),
        .swap_pending(swap_pending), .swap_done(swap_done),
        .busy(busy),
        .rd_color(rd_color), .rd_row(rd_row),
        .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    // Model: two frames indexed [buffer][color*8+row], front index,
    // cycles left in a clear sweep, pending swap flag.
    logic [7:0] m_mem [2][16];
    logic       m_front;
    int         m_cnt = 0;
    logic       m_pending;
    logic       m_done;
    logic [7:0] m_rd;
    logic       m_idle;

    assign m_idle = (m_cnt == 0) && !m_pending;

    task automatic chk(input string nm, input logic [7:0] got,
                       input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
        end
    endtask

    // Model update on each clock edge.
    always @(posedge clk) begin
        if (rst) begin
            m_front   <= 1'b0;
            m_pending <= 1'b0;
            m_cnt     <= 0;
            m_done    <= 1'b0;
            m_rd      <= 8'h00;
            for (int b = 0; b < 2; b++)
                for (int r = 0; r < 16; r++)
                    m_mem[b][r] <= CV;
        end else begin
            m_rd   <= m_mem[m_front][{rd_color, rd_row}];
            m_done <= 1'b0;
            if (m_idle && wr_valid)
                m_mem[m_front ^ 1'b1][{wr_color, wr_row}] <=
                    (m_mem[m_front ^ 1'b1][{wr_color, wr_row}] & ~wr_mask)
                    | (wr_data & wr_mask);
            if (m_cnt != 0) begin
                m_mem[m_front ^ 1'b1][16 - m_cnt] <= CV;
                m_cnt <= m_cnt - 1;
            end else if (m_pending) begin
                if (frame_start) begin
                    m_front   <= m_front ^ 1'b1;
                    m_pending <= 1'b0;
                    m_done    <= 1'b1;
                end
            end else if (clear_req) begin
                m_cnt <= 16;
            end else if (swap_req) begin
                m_pending <= 1'b1;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (started) begin
            chk("wr_ready", {7'b0, wr_ready}, {7'b0, !rst && m_idle});
            chk("busy", {7'b0, busy}, {7'b0, !m_idle});
            chk("swap_pending", {7'b0, swap_pending}, {7'b0, m_pending});
            chk("swap_done", {7'b0, swap_done}, {7'b0, m_done});
            chk("rd_data", rd_data, m_rd);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wr(input logic c, input logic [2:0] r,
                      input logic [7:0] m, input logic [7:0] d);
        wr_valid = 1'b1; wr_color = c; wr_row = r;
        wr_mask = m; wr_data = d;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic do_swap();
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic rd(input logic c, input logic [2:0] r,
                      input string nm, input logic [7:0] exp);
        rd_color = c; rd_row = r;
        tick();
        chk(nm, rd_data, exp);
    endtask

    int n;

    initial begin
        tick();
        started = 1;
        tick();
        chk("rst_wr_ready", {7'b0, wr_ready}, 8'h00);
        chk("rst_busy", {7'b0, busy}, 8'h00);
        chk("rst_rd_data", rd_data, 8'h00);
        rst = 1'b0;
        #1;
        chk("idle_wr_ready", {7'b0, wr_ready}, 8'h01);

        // Write, swap, read back through the front buffer.
        wr(1'b0, 3'd3, 8'hFF, 8'hA5);
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        chk("sw_pending", {7'b0, swap_pending}, 8'h01);
        chk("sw_wr_ready", {7'b0, wr_ready}, 8'h00);
        tick();
        chk("sw_wait_pending", {7'b0, swap_pending}, 8'h01);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("sw_done", {7'b0, swap_done}, 8'h01);
        chk("sw_cleared", {7'b0, swap_pending}, 8'h00);
        rd(1'b0, 3'd3, "rd_a5", 8'hA5);
        chk("model_rd_a5", m_rd, 8'hA5);
        chk("sw_done_once", {7'b0, swap_done}, 8'h00);

        // Masked merge F0 + mask 0F data 05 -> F5.
        wr(1'b1, 3'd5, 8'hFF, 8'hF0);
        wr(1'b1, 3'd5, 8'h0F, 8'h05);
        do_swap();
        rd(1'b1, 3'd5, "mask_f5", 8'hF5);
        chk("model_rd_f5", m_rd, 8'hF5);
        rd(1'b0, 3'd3, "other_buf_00", 8'h00);

        // Clear sweep of the back buffer: exactly 16 busy cycles.
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        n = 0;
        for (int k = 0; k < 40; k++) begin
            if (!busy) break;
            if (!wr_ready) n++;
            tick();
        end
        chk("clear_cycles", n[7:0], 8'd16);
        rd(1'b1, 3'd5, "clear_front_kept", 8'hF5);
        do_swap();
        rd(1'b0, 3'd3, "cleared_a5", CV);
        rd(1'b1, 3'd5, "cleared_f5", CV);

        // Swap request coinciding with frame_start waits a frame.
        swap_req = 1'b1;
        frame_start = 1'b1;
        tick();
        swap_req = 1'b0;
        frame_start = 1'b0;
        chk("coinc_done", {7'b0, swap_done}, 8'h00);
        chk("coinc_pending", {7'b0, swap_pending}, 8'h01);
        tick();
        chk("coinc_still", {7'b0, swap_pending}, 8'h01);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("coinc_done2", {7'b0, swap_done}, 8'h01);
        rd(1'b1, 3'd5, "old_front_kept", 8'hF5);

        // Clear and swap together: clear wins, no swap.
        clear_req = 1'b1;
        swap_req = 1'b1;
        tick();
        clear_req = 1'b0;
        swap_req = 1'b0;
        chk("cs_busy", {7'b0, busy}, 8'h01);
        chk("cs_pending", {7'b0, swap_pending}, 8'h00);
        for (int k = 0; k < 40 && busy; k++) tick();
        chk("cs_idle", {7'b0, busy}, 8'h00);
        chk("cs_pending2", {7'b0, swap_pending}, 8'h00);
        rd(1'b1, 3'd5, "cs_front", 8'hF5);

        // Reset during SWAP_WAIT aborts the swap.
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("abort_done", {7'b0, swap_done}, 8'h00);
        chk("abort_busy", {7'b0, busy}, 8'h00);
        for (int a = 0; a < 16; a++) begin
            rd(a[3], a[2:0], "abort_rd", CV);
        end

        // Randomized traffic checked by the compare process.
        for (int k = 0; k < 4000; k++) begin
            rst         = ($urandom_range(0, 199) == 0);
            wr_valid    = $urandom_range(0, 1) == 1;
            wr_color    = 1'($urandom_range(0, 1));
            wr_row      = 3'($urandom_range(0, 7));
            wr_mask     = 8'($urandom);
            wr_data     = 8'($urandom);
            clear_req   = ($urandom_range(0, 39) == 0);
            swap_req    = ($urandom_range(0, 11) == 0);
            frame_start = ($urandom_range(0, 7) == 0);
            rd_color    = 1'($urandom_range(0, 1));
            rd_row      = 3'($urandom_range(0, 7));
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
